status_ctrl: RTL and testbench

//  Owns the architectural status state: 6-bit compressed flags {AF,CF,OF,SF,ZF,PF} plus DF.

---
 rtl/status_ctrl_pkg.sv | 41 ++++
 rtl/status_ctrl_ahmap.sv | 40 ++++
 rtl/status_ctrl.sv | 171 +++++++++++++++++
 tb/tb_status_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/status_ctrl_pkg.sv
// status_ctrl_pkg
//   Shared definitions for the status controller:
//   - bit indices of the compressed status word {AF,CF,OF,SF,ZF,PF}
//   - bit positions of those flags inside the AH byte (LAHF/SAHF layout)
//   - meta command opcodes
//   - FSM state encoding
package status_ctrl_pkg;

   // Compressed status bit indices
   localparam int STAT_AF = 5;
   localparam int STAT_CF = 4;
   localparam int STAT_OF = 3;
   localparam int STAT_SF = 2;
   localparam int STAT_ZF = 1;
   localparam int STAT_PF = 0;

   // AH byte layout: {SF,ZF,0,AF,0,PF,1,CF}
   localparam int AH_SF = 7;
   localparam int AH_ZF = 6;
   localparam int AH_AF = 4;
   localparam int AH_PF = 2;
   localparam int AH_CF = 0;

   // Meta command opcodes
   localparam logic [5:0] CMD_CLC  = 6'h01;
   localparam logic [5:0] CMD_STC  = 6'h02;
   localparam logic [5:0] CMD_CMC  = 6'h03;
   localparam logic [5:0] CMD_CLD  = 6'h04;
   localparam logic [5:0] CMD_STD  = 6'h05;
   localparam logic [5:0] CMD_LAHF = 6'h06;
   localparam logic [5:0] CMD_SAHF = 6'h07;

   // Controller FSM states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RF_RD = 2'd1,
      ST_RF_WR = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

endpackage

// File: rtl/status_ctrl_ahmap.sv
// status_ctrl_ahmap
//   Combinational pack/unpack between the compressed status word and the
//   AH byte used by LAHF/SAHF.
// Ports
//   status        in   6  current compressed flags
//   ah_rd         in   8  AH byte read from the register file
//   ah_pack       out  8  {SF,ZF,0,AF,0,PF,1,CF} built from status
//   status_unpack out  6  status with SF/ZF/AF/PF/CF taken from ah_rd, OF kept
module status_ctrl_ahmap
   import status_ctrl_pkg::*;
(
   input  logic [5:0] status,
   input  logic [7:0] ah_rd,
   output logic [7:0] ah_pack,
   output logic [5:0] status_unpack
);

   // Reserved AH bits carry no flag information on the way in.
   logic unused_ah;
   assign unused_ah = ^{ah_rd[5], ah_rd[3], ah_rd[1]};

   always_comb begin
      ah_pack        = 8'b0000_0010;   // bit 1 always reads as 1
      ah_pack[AH_SF] = status[STAT_SF];
      ah_pack[AH_ZF] = status[STAT_ZF];
      ah_pack[AH_AF] = status[STAT_AF];
      ah_pack[AH_PF] = status[STAT_PF];
      ah_pack[AH_CF] = status[STAT_CF];
   end

   always_comb begin
      status_unpack          = status;  // OF is not represented in AH
      status_unpack[STAT_SF] = ah_rd[AH_SF];
      status_unpack[STAT_ZF] = ah_rd[AH_ZF];
      status_unpack[STAT_AF] = ah_rd[AH_AF];
      status_unpack[STAT_PF] = ah_rd[AH_PF];
      status_unpack[STAT_CF] = ah_rd[AH_CF];
   end

endmodule

// File: rtl/status_ctrl.sv
// status_ctrl
//   Owns the architectural flags {AF,CF,OF,SF,ZF,PF} and DF. Executes the
//   meta commands CLC/STC/CMC/CLD/STD/LAHF/SAHF, merges ALU flag updates and
//   drives a single-byte AH register-file port for LAHF/SAHF.
// Handshakes
//   cmd: a command transfers on a rising edge where cmd_vld && cmd_rdy.
//        cmd_rdy is high only in IDLE.
//   alu: an update transfers on a rising edge where alu_vld && alu_rdy.
//        alu_rdy is high in IDLE and RESP. Valid may be held or dropped
//        freely by the source; nothing is latched without ready.
//   rf : rf_req/rf_we/rf_wdata stay stable until a cycle with rf_gnt; read
//        data is taken from rf_rdata in that grant cycle.
// Ports
//   clk, rst_n           clock, async active-low reset
//   cmd_vld/rdy/opc      meta command handshake
//   alu_vld/rdy/flags/mask ALU flag update handshake
//   rf_req/we/wdata/gnt/rdata AH register-file port
//   status_out, df_out   current flags (registered)
//   done, err            one-cycle retire / error pulses
//   dbg_state            current FSM state
module status_ctrl
   import status_ctrl_pkg::*;
#(
   parameter int STAT_W  = 6,
   parameter int TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_vld,
   output logic              cmd_rdy,
   input  logic [5:0]        cmd_opc,
   input  logic              alu_vld,
   output logic              alu_rdy,
   input  logic [STAT_W-1:0] alu_flags,
   input  logic [STAT_W-1:0] alu_mask,
   output logic              rf_req,
   output logic              rf_we,
   output logic [7:0]        rf_wdata,
   input  logic              rf_gnt,
   input  logic [7:0]        rf_rdata,
   output logic [STAT_W-1:0] status_out,
   output logic              df_out,
   output logic              done,
   output logic              err,
   output logic [1:0]        dbg_state
);

   localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

   state_t            state;
   logic [TW-1:0]     timer;
   logic [STAT_W-1:0] status_q;
   logic              df_q;

   logic              cmd_fire;
   logic              alu_fire;
   logic [STAT_W-1:0] merged;
   logic [7:0]        ah_pack;
   logic [STAT_W-1:0] status_unpack;

   assign cmd_rdy    = (state == ST_IDLE);
   assign alu_rdy    = (state == ST_IDLE) || (state == ST_RESP);
   assign cmd_fire   = cmd_vld && cmd_rdy;
   assign alu_fire   = alu_vld && alu_rdy;
   assign status_out = status_q;
   assign df_out     = df_q;
   assign dbg_state  = state;

   // Flags after any ALU merge this cycle; meta commands act on this value,
   // so a same-cycle CF command overrides the ALU's CF.
   assign merged = alu_fire ? ((status_q & ~alu_mask) | (alu_flags & alu_mask))
                            : status_q;

   status_ctrl_ahmap u_ahmap (
      .status        (merged),
      .ah_rd         (rf_rdata),
      .ah_pack       (ah_pack),
      .status_unpack (status_unpack)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         timer    <= '0;
         status_q <= '0;
         df_q     <= 1'b0;
         rf_req   <= 1'b0;
         rf_we    <= 1'b0;
         rf_wdata <= 8'h00;
         done     <= 1'b0;
         err      <= 1'b0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         case (state)
            ST_IDLE: begin
               status_q <= merged;
               if (cmd_fire) begin
                  case (cmd_opc)
                     CMD_CLC: begin
                        status_q[STAT_CF] <= 1'b0;
                        state <= ST_RESP;
                        done  <= 1'b1;
                     end
                     CMD_STC: begin
                        status_q[STAT_CF] <= 1'b1;
                        state <= ST_RESP;
                        done  <= 1'b1;
                     end
                     CMD_CMC: begin
                        status_q[STAT_CF] <= ~merged[STAT_CF];
                        state <= ST_RESP;
                        done  <= 1'b1;
                     end
                     CMD_CLD: begin
                        df_q  <= 1'b0;
                        state <= ST_RESP;
                        done  <= 1'b1;
                     end
                     CMD_STD: begin
                        df_q  <= 1'b1;
                        state <= ST_RESP;
                        done  <= 1'b1;
                     end
                     CMD_LAHF: begin
                        rf_wdata <= ah_pack;
                        rf_req   <= 1'b1;
                        rf_we    <= 1'b1;
                        timer    <= '0;
                        state    <= ST_RF_WR;
                     end
                     CMD_SAHF: begin
                        rf_req <= 1'b1;
                        rf_we  <= 1'b0;
                        timer  <= '0;
                        state  <= ST_RF_RD;
                     end
                     default: err <= 1'b1;
                  endcase
               end
            end
            ST_RF_RD, ST_RF_WR: begin
               if (rf_gnt) begin
                  if (state == ST_RF_RD) status_q <= status_unpack;
                  rf_req <= 1'b0;
                  rf_we  <= 1'b0;
                  timer  <= '0;
                  done   <= 1'b1;
                  state  <= ST_RESP;
               end else if (timer == TMAX) begin
                  // Grant never came: abort without touching the flags.
                  rf_req <= 1'b0;
                  rf_we  <= 1'b0;
                  timer  <= '0;
                  err    <= 1'b1;
                  state  <= ST_IDLE;
               end else begin
                  timer <= timer + TW'(1);
               end
            end
            ST_RESP: begin
               status_q <= merged;
               state    <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_status_ctrl.sv
// tb_status_ctrl
//   Directed self-checking bench for status_ctrl. Inputs change on the
//   falling edge; outputs are sampled 1 ns after the rising edge.
module tb_status_ctrl;
   import status_ctrl_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cmd_vld = 1'b0;
   logic       cmd_rdy;
   logic [5:0] cmd_opc = 6'h00;
   logic       alu_vld = 1'b0;
   logic       alu_rdy;
   logic [5:0] alu_flags = 6'h00;
   logic [5:0] alu_mask = 6'h00;
   logic       rf_req;
   logic       rf_we;
   logic [7:0] rf_wdata;
   logic       rf_gnt = 1'b0;
   logic [7:0] rf_rdata = 8'h00;
   logic [5:0] status_out;
   logic       df_out;
   logic       done;
   logic       err;
   logic [1:0] dbg_state;

   int n_checks = 0;
   int n_fail   = 0;

   status_ctrl #(.STAT_W(6), .TIMEOUT(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_opc(cmd_opc),
      .alu_vld(alu_vld), .alu_rdy(alu_rdy), .alu_flags(alu_flags), .alu_mask(alu_mask),
      .rf_req(rf_req), .rf_we(rf_we), .rf_wdata(rf_wdata), .rf_gnt(rf_gnt), .rf_rdata(rf_rdata),
      .status_out(status_out), .df_out(df_out), .done(done), .err(err), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   // Present a command for one accepting edge; returns 1 ns after that edge.
   task automatic issue(input logic [5:0] opc);
      @(negedge clk);
      cmd_vld = 1'b1;
      cmd_opc = opc;
      @(posedge clk);
      #1;
      cmd_vld = 1'b0;
   endtask

   // Present an ALU update for one edge (in IDLE).
   task automatic alu_write(input logic [5:0] f, input logic [5:0] m);
      @(negedge clk);
      alu_vld   = 1'b1;
      alu_flags = f;
      alu_mask  = m;
      @(posedge clk);
      #1;
      alu_vld = 1'b0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_checks++; if (status_out !== 6'h00) begin n_fail++; $display("FAIL reset_status got=%h exp=00", status_out); end
      n_checks++; if (df_out !== 1'b0) begin n_fail++; $display("FAIL reset_df got=%b exp=0", df_out); end
      n_checks++; if ({rf_req, rf_we, rf_wdata} !== 10'h000) begin n_fail++; $display("FAIL reset_rf got=%b%b%h exp=0000", rf_req, rf_we, rf_wdata); end
      n_checks++; if ({done, err} !== 2'b00) begin n_fail++; $display("FAIL reset_pulses got=%b%b exp=00", done, err); end
      n_checks++; if ({cmd_rdy, alu_rdy} !== 2'b11) begin n_fail++; $display("FAIL reset_rdy got=%b%b exp=11", cmd_rdy, alu_rdy); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_cf_ops();
      logic [5:0] opcs [4];
      logic [5:0] exps [4];
      opcs = '{CMD_CLC, CMD_STC, CMD_CMC, CMD_CMC};
      exps = '{6'h00, 6'h10, 6'h00, 6'h10};
      for (int i = 0; i < 4; i++) begin
         issue(opcs[i]);
         n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL cf_op%0d_done got=%b exp=1", i, done); end
         n_checks++; if (status_out !== exps[i]) begin n_fail++; $display("FAIL cf_op%0d_status got=%h exp=%h", i, status_out, exps[i]); end
         n_checks++; if (cmd_rdy !== 1'b0) begin n_fail++; $display("FAIL cf_op%0d_resp_rdy got=%b exp=0", i, cmd_rdy); end
         step();
         n_checks++; if ({done, cmd_rdy} !== 2'b01) begin n_fail++; $display("FAIL cf_op%0d_idle got=%b%b exp=01", i, done, cmd_rdy); end
      end
   endtask

   task automatic test_lahf();
      alu_write(6'b110110, 6'h3F);
      issue(CMD_LAHF);
      n_checks++; if ({rf_req, rf_we} !== 2'b11) begin n_fail++; $display("FAIL lahf_req got=%b%b exp=11", rf_req, rf_we); end
      n_checks++; if (rf_wdata !== 8'hD3) begin n_fail++; $display("FAIL lahf_wdata got=%h exp=d3", rf_wdata); end
      n_checks++; if ({cmd_rdy, alu_rdy} !== 2'b00) begin n_fail++; $display("FAIL lahf_rdy got=%b%b exp=00", cmd_rdy, alu_rdy); end
      repeat (2) step();
      n_checks++; if ({rf_req, rf_wdata, done} !== 10'b1_1101_0011_0) begin n_fail++; $display("FAIL lahf_hold got=%b %h %b exp=1 d3 0", rf_req, rf_wdata, done); end
      @(negedge clk);
      rf_gnt = 1'b1;
      @(posedge clk);
      #1;
      rf_gnt = 1'b0;
      n_checks++; if ({rf_req, done} !== 2'b01) begin n_fail++; $display("FAIL lahf_gnt got=%b%b exp=01", rf_req, done); end
      n_checks++; if (status_out !== 6'b110110) begin n_fail++; $display("FAIL lahf_status got=%b exp=110110", status_out); end
      step();
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL lahf_done_once got=%b exp=0", done); end
   endtask

   task automatic test_sahf();
      alu_write(6'h3F, 6'h3F);
      issue(CMD_SAHF);
      n_checks++; if ({rf_req, rf_we} !== 2'b10) begin n_fail++; $display("FAIL sahf_req got=%b%b exp=10", rf_req, rf_we); end
      // An ALU update offered while waiting must be refused.
      @(negedge clk);
      alu_vld = 1'b1; alu_flags = 6'h00; alu_mask = 6'h3F;
      #1;
      n_checks++; if (alu_rdy !== 1'b0) begin n_fail++; $display("FAIL sahf_alu_rdy got=%b exp=0", alu_rdy); end
      step();
      n_checks++; if (status_out !== 6'h3F) begin n_fail++; $display("FAIL sahf_no_merge got=%h exp=3f", status_out); end
      @(negedge clk);
      alu_vld = 1'b0; rf_gnt = 1'b1; rf_rdata = 8'h44;
      @(posedge clk);
      #1;
      rf_gnt = 1'b0;
      n_checks++; if (status_out !== 6'b001011) begin n_fail++; $display("FAIL sahf_status got=%b exp=001011", status_out); end
      n_checks++; if ({rf_req, done} !== 2'b01) begin n_fail++; $display("FAIL sahf_done got=%b%b exp=01", rf_req, done); end
      step();
   endtask

   task automatic test_same_cycle();
      @(negedge clk);
      alu_vld = 1'b1; alu_flags = 6'h3F; alu_mask = 6'h3F;
      cmd_vld = 1'b1; cmd_opc = CMD_STC;
      step();
      alu_vld = 1'b0; cmd_vld = 1'b0;
      n_checks++; if (status_out !== 6'h3F) begin n_fail++; $display("FAIL same_stc got=%h exp=3f", status_out); end
      step();
      @(negedge clk);
      alu_vld = 1'b1; alu_flags = 6'h10; alu_mask = 6'h10;
      cmd_vld = 1'b1; cmd_opc = CMD_CLC;
      step();
      alu_vld = 1'b0; cmd_vld = 1'b0;
      n_checks++; if (status_out !== 6'h2F) begin n_fail++; $display("FAIL same_clc got=%h exp=2f", status_out); end
      // Now in RESP: an ALU update still merges.
      @(negedge clk);
      alu_vld = 1'b1; alu_flags = 6'h00; alu_mask = 6'h01;
      #1;
      n_checks++; if (alu_rdy !== 1'b1) begin n_fail++; $display("FAIL resp_alu_rdy got=%b exp=1", alu_rdy); end
      step();
      alu_vld = 1'b0;
      n_checks++; if (status_out !== 6'h2E) begin n_fail++; $display("FAIL resp_merge got=%h exp=2e", status_out); end
   endtask

   task automatic test_timeout();
      int  cnt;
      logic saw_done;
      cnt = 0;
      saw_done = 1'b0;
      issue(CMD_LAHF);
      while (cnt < 40 && err !== 1'b1) begin
         step();
         cnt++;
         if (done === 1'b1) saw_done = 1'b1;
      end
      n_checks++; if (cnt !== 16) begin n_fail++; $display("FAIL timeout_cycles got=%0d exp=16", cnt); end
      n_checks++; if (saw_done !== 1'b0) begin n_fail++; $display("FAIL timeout_done got=%b exp=0", saw_done); end
      n_checks++; if ({rf_req, cmd_rdy} !== 2'b01) begin n_fail++; $display("FAIL timeout_idle got=%b%b exp=01", rf_req, cmd_rdy); end
      n_checks++; if (status_out !== 6'h2E) begin n_fail++; $display("FAIL timeout_status got=%h exp=2e", status_out); end
      step();
      n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL timeout_err_once got=%b exp=0", err); end
   endtask

   task automatic test_illegal_and_reset();
      issue(6'h3F);
      n_checks++; if ({err, done} !== 2'b10) begin n_fail++; $display("FAIL illegal_pulse got=%b%b exp=10", err, done); end
      n_checks++; if ({status_out, df_out, cmd_rdy} !== {6'h2E, 1'b0, 1'b1}) begin n_fail++; $display("FAIL illegal_state got=%h %b %b exp=2e 0 1", status_out, df_out, cmd_rdy); end
      step();
      issue(CMD_STD);
      n_checks++; if ({df_out, done} !== 2'b11) begin n_fail++; $display("FAIL std got=%b%b exp=11", df_out, done); end
      step();
      issue(CMD_SAHF);
      n_checks++; if (rf_req !== 1'b1) begin n_fail++; $display("FAIL rst_sahf_req got=%b exp=1", rf_req); end
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++; if ({rf_req, df_out, done, err} !== 4'b0000) begin n_fail++; $display("FAIL rst_abort got=%b%b%b%b exp=0000", rf_req, df_out, done, err); end
      n_checks++; if ({status_out, dbg_state} !== 8'h00) begin n_fail++; $display("FAIL rst_state got=%h %0d exp=00 0", status_out, dbg_state); end
      @(negedge clk);
      rst_n = 1'b1;
      step();
      n_checks++; if ({done, err, cmd_rdy} !== 3'b001) begin n_fail++; $display("FAIL post_rst got=%b%b%b exp=001", done, err, cmd_rdy); end
   endtask

   initial begin
      test_reset();
      test_cf_ops();
      test_lahf();
      test_sahf();
      test_same_cycle();
      test_timeout();
      test_illegal_and_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
